// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: one-entry MEM/WB register with load extraction, stall/flush handshake, forwarding tap and retire counter
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid / in_ready      memory-stage handshake
//   in_*                     memory-stage fields (select, rd, load funct3/address, candidate data)
//   stall, flush             hazard-unit controls for the held entry
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   fwd_valid/fwd_rd/fwd_data forwarding tap of the held entry
//   misalign_err             pulse when a misaligned or illegal load retires
//   retire_cnt               saturating committed-instruction count
module wb_pipe_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 32
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_wb_sel,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [2:0]         in_ld_funct3,
   input  logic [2:0]         in_addr_lo,
   input  logic [XLEN-1:0]    in_mem_dout,
   input  logic [XLEN-1:0]    in_alu_res,
   input  logic [XLEN-1:0]    in_imme,
   input  logic [XLEN-1:0]    in_pc_add_4,
   input  logic [XLEN-1:0]    in_pc_add_imme,
   input  logic               stall,
   input  logic               flush,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]    fwd_data,
   output logic               misalign_err,
   output logic [CNT_W-1:0]   retire_cnt
);
   logic [2:0] alo;
   logic [XLEN-1:0] sh, ld_b, ld_h, ld_w, ld_data, wdata, wdata_q;
   logic mis, illegal, bad, we_ok;
   logic valid_q, we_ok_q, bad_q, commit, take;
   logic [RADDR_W-1:0] rd_q;
   // Write data and the bad-load verdict are resolved at capture so the held entry is ready to commit and forward.
   always_comb begin
      alo = (XLEN == 64) ? in_addr_lo : {1'b0, in_addr_lo[1:0]};
      sh = in_mem_dout >> {alo, 3'b000};
      ld_b = in_ld_funct3[2] ? XLEN'(sh[7:0]) : XLEN'($signed(sh[7:0]));
      ld_h = in_ld_funct3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      ld_w = in_ld_funct3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      ld_data = (in_ld_funct3[1:0] == 2'd0) ? ld_b :
                (in_ld_funct3[1:0] == 2'd1) ? ld_h :
                (in_ld_funct3[1:0] == 2'd2) ? ld_w : sh;
      mis = (in_ld_funct3[1:0] == 2'd1) ? alo[0] :
            (in_ld_funct3[1:0] == 2'd2) ? |alo[1:0] :
            (in_ld_funct3[1:0] == 2'd3) ? |alo : 1'b0;
      illegal = (in_ld_funct3 == 3'b111) |
                ((XLEN == 32) & ((in_ld_funct3 == 3'b011) | (in_ld_funct3 == 3'b110)));
      bad = (in_wb_sel == 3'd1) & (mis | illegal);
      wdata = (in_wb_sel == 3'd1) ? (bad ? '0 : ld_data) :
              (in_wb_sel == 3'd2) ? in_alu_res :
              (in_wb_sel == 3'd3) ? in_imme :
              (in_wb_sel == 3'd4) ? in_pc_add_4 :
              (in_wb_sel == 3'd5) ? in_pc_add_imme : '0;
      we_ok = (in_wb_sel != 3'd0) & (in_wb_sel <= 3'd5) & (|in_rd) & ~bad;
   end
   assign in_ready     = ~valid_q | ~stall;
   assign commit       = valid_q & ~stall & ~flush;
   assign take         = in_valid & in_ready & ~flush;
   assign rf_we        = commit & we_ok_q;
   assign misalign_err = commit & bad_q;
   assign fwd_valid    = valid_q & we_ok_q;
   assign rf_waddr     = rd_q;
   assign rf_wdata     = wdata_q;
   assign fwd_rd       = rd_q;
   assign fwd_data     = wdata_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         we_ok_q    <= 1'b0;
         bad_q      <= 1'b0;
         rd_q       <= '0;
         wdata_q    <= '0;
         retire_cnt <= '0;
      end else begin
         if (take) begin
            valid_q <= 1'b1;
            we_ok_q <= we_ok;
            bad_q   <= bad;
            rd_q    <= in_rd;
            wdata_q <= wdata;
         end else if (commit | flush) begin
            valid_q <= 1'b0;
         end
         if (commit & ~&retire_cnt) retire_cnt <= retire_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_wb_pipe_stage.sv
module tb_wb_pipe_stage;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic in_valid, stall, flush;
   logic [2:0] in_wb_sel, in_ld_funct3, in_addr_lo;
   logic [4:0] in_rd;
   logic [31:0] in_mem_dout, in_alu_res, in_imme, in_pc_add_4, in_pc_add_imme;
   logic in_ready, rf_we, fwd_valid, misalign_err;
   logic [4:0] rf_waddr, fwd_rd;
   logic [31:0] rf_wdata, fwd_data, retire_cnt;
   logic in_ready2, rf_we2, fwd_valid2, misalign_err2;
   logic [4:0] rf_waddr2, fwd_rd2;
   logic [31:0] rf_wdata2, fwd_data2;
   logic [1:0] retire_cnt2;

   wb_pipe_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wb_sel(in_wb_sel),
      .in_rd(in_rd), .in_ld_funct3(in_ld_funct3), .in_addr_lo(in_addr_lo), .in_mem_dout(in_mem_dout),
      .in_alu_res(in_alu_res), .in_imme(in_imme), .in_pc_add_4(in_pc_add_4), .in_pc_add_imme(in_pc_add_imme),
      .stall(stall), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .misalign_err(misalign_err),
      .retire_cnt(retire_cnt));

   wb_pipe_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_wb_sel(in_wb_sel),
      .in_rd(in_rd), .in_ld_funct3(in_ld_funct3), .in_addr_lo(in_addr_lo), .in_mem_dout(in_mem_dout),
      .in_alu_res(in_alu_res), .in_imme(in_imme), .in_pc_add_4(in_pc_add_4), .in_pc_add_imme(in_pc_add_imme),
      .stall(stall), .flush(flush), .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
      .fwd_valid(fwd_valid2), .fwd_rd(fwd_rd2), .fwd_data(fwd_data2), .misalign_err(misalign_err2),
      .retire_cnt(retire_cnt2));

   typedef struct {
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [2:0]  alo;
      logic        we;
      logic        err;
      logic [31:0] data;
   } vec_t;
   typedef struct {
      logic        we;
      logic        err;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   vec_t v[18];
   vec_t jal, a, b;
   int checks = 0, errors = 0, cnt_m = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      in_valid = 1'b1;
      in_wb_sel = x.sel;
      in_rd = x.rd;
      in_ld_funct3 = x.f3;
      in_addr_lo = x.alo;
   endtask

   task automatic push(input vec_t x);
      exp_t e;
      e.we = x.we;
      e.err = x.err;
      e.rd = x.rd;
      e.data = x.data;
      if (x.we | x.err) q.push_back(e);
      cnt_m++;
   endtask

   task automatic fwd_chk(input vec_t x);
      chk("fwd_valid", 64'(fwd_valid), 64'(x.we));
      if (x.we) begin
         chk("fwd_rd", 64'(fwd_rd), 64'(x.rd));
         chk("fwd_data", 64'(fwd_data), 64'(x.data));
      end
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
      chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(0));
      chk({tag, "_misalign"}, 64'(misalign_err), 64'(0));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(0));
      chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(0));
      chk({tag, "_fwd_rd"}, 64'(fwd_rd), 64'(0));
      chk({tag, "_fwd_data"}, 64'(fwd_data), 64'(0));
      chk({tag, "_retire_cnt"}, 64'(retire_cnt), 64'(0));
      chk({tag, "_retire_cnt2"}, 64'(retire_cnt2), 64'(0));
   endtask

   // Every write or error pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (rf_we || misalign_err)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: we=%b err=%b rd=%0d data=%h, none expected", rf_we, misalign_err, rf_waddr, rf_wdata);
         end else begin
            e = q.pop_front();
            chk("ev_we", 64'(rf_we), 64'(e.we));
            chk("ev_err", 64'(misalign_err), 64'(e.err));
            if (e.we) begin
               chk("ev_waddr", 64'(rf_waddr), 64'(e.rd));
               chk("ev_wdata", 64'(rf_wdata), 64'(e.data));
            end
         end
      end
   end

   initial begin
      v[0]  = '{3'd2, 5'd5,  3'd0, 3'd0, 1'b1, 1'b0, 32'h12345678};
      v[1]  = '{3'd1, 5'd1,  3'd0, 3'd3, 1'b1, 1'b0, 32'hFFFFFF80};
      v[2]  = '{3'd1, 5'd2,  3'd4, 3'd3, 1'b1, 1'b0, 32'h00000080};
      v[3]  = '{3'd1, 5'd3,  3'd1, 3'd2, 1'b1, 1'b0, 32'hFFFF80FF};
      v[4]  = '{3'd1, 5'd4,  3'd2, 3'd0, 1'b1, 1'b0, 32'h80FF7F01};
      v[5]  = '{3'd1, 5'd6,  3'd1, 3'd1, 1'b0, 1'b1, 32'h0};
      v[6]  = '{3'd1, 5'd7,  3'd5, 3'd0, 1'b1, 1'b0, 32'h00007F01};
      v[7]  = '{3'd1, 5'd8,  3'd0, 3'd1, 1'b1, 1'b0, 32'h0000007F};
      v[8]  = '{3'd3, 5'd9,  3'd0, 3'd0, 1'b1, 1'b0, 32'hDEAD0000};
      v[9]  = '{3'd4, 5'd10, 3'd0, 3'd0, 1'b1, 1'b0, 32'h00000104};
      v[10] = '{3'd5, 5'd31, 3'd0, 3'd0, 1'b1, 1'b0, 32'h00002000};
      v[11] = '{3'd1, 5'd11, 3'd3, 3'd0, 1'b0, 1'b1, 32'h0};
      v[12] = '{3'd1, 5'd12, 3'd6, 3'd0, 1'b0, 1'b1, 32'h0};
      v[13] = '{3'd1, 5'd13, 3'd2, 3'd2, 1'b0, 1'b1, 32'h0};
      v[14] = '{3'd1, 5'd14, 3'd7, 3'd0, 1'b0, 1'b1, 32'h0};
      v[15] = '{3'd0, 5'd15, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0};
      v[16] = '{3'd7, 5'd16, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0};
      v[17] = '{3'd2, 5'd0,  3'd0, 3'd0, 1'b0, 1'b0, 32'h0};
      jal   = '{3'd4, 5'd9,  3'd0, 3'd0, 1'b1, 1'b0, 32'h00000104};
      a     = '{3'd2, 5'd6,  3'd0, 3'd0, 1'b1, 1'b0, 32'h12345678};
      b     = '{3'd2, 5'd7,  3'd0, 3'd0, 1'b1, 1'b0, 32'h12345678};
      in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      in_wb_sel = 3'd0; in_rd = 5'd0; in_ld_funct3 = 3'd0; in_addr_lo = 3'd0;
      in_mem_dout = 32'h80FF7F01; in_alu_res = 32'h12345678; in_imme = 32'hDEAD0000;
      in_pc_add_4 = 32'h00000104; in_pc_add_imme = 32'h00002000;
      repeat (2) @(posedge clk);
      #1;
      zero_chk("reset");
      rst = 1'b0;

      // Table vectors back to back; the entry driven one cycle earlier is the one held now.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         drive(v[i]);
         push(v[i]);
         @(negedge clk);
         chk("in_ready", 64'(in_ready), 64'(1));
         chk("retire_cnt_run", 64'(retire_cnt), 64'((i > 0) ? i - 1 : 0));
         if (i > 0) fwd_chk(v[i-1]);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      fwd_chk(v[17]);
      repeat (2) @(negedge clk);
      chk("retire_cnt_table", 64'(retire_cnt), 64'(cnt_m));
      chk("retire_cnt_sat", 64'(retire_cnt2), 64'(3));

      // JAL held under a three-cycle stall.
      @(posedge clk);
      #1;
      drive(jal);
      stall = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_fwd_valid", 64'(fwd_valid), 64'(1));
         chk("stall_fwd_rd", 64'(fwd_rd), 64'(9));
         chk("stall_fwd_data", 64'(fwd_data), 64'(32'h104));
         chk("stall_rf_we", 64'(rf_we), 64'(0));
         chk("stall_retire_cnt", 64'(retire_cnt), 64'(cnt_m));
      end
      @(posedge clk);
      #1;
      push(jal);
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stall_retire_after", 64'(retire_cnt), 64'(cnt_m));

      // Flush a held entry while a new one is offered.
      @(posedge clk);
      #1;
      drive(a);
      stall = 1'b1;
      @(posedge clk);
      #1;
      drive(b);
      stall = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_rf_we", 64'(rf_we), 64'(0));
      chk("flush_misalign", 64'(misalign_err), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_not_captured", 64'(fwd_valid), 64'(0));
      chk("flush_rf_we_after", 64'(rf_we), 64'(0));
      chk("flush_retire_cnt", 64'(retire_cnt), 64'(cnt_m));

      // Four ALU writes back to back.
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         b.rd = 5'(i);
         drive(b);
         push(b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("b2b_retire_cnt", 64'(retire_cnt), 64'(cnt_m));
      chk("b2b_retire_sat", 64'(retire_cnt2), 64'(3));
      chk("queue_drained", 64'(q.size()), 64'(0));

      // Asynchronous reset while an entry is held under stall.
      @(posedge clk);
      #1;
      drive(a);
      stall = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_held", 64'(fwd_valid), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      zero_chk("async_reset");
      @(negedge clk);
      zero_chk("reset_next_cycle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Registered, parametrised write-back stage for the pipelined core. It replaces the combinational write-back mux with a one-entry MEM/WB register, and adds four functions:
- load byte/half/word extraction with sign/zero extension and misalignment detection;
- stall/flush handshake;
- a forwarding tap for the hazard unit;
- a saturating retired-instruction counter.

It sits between the memory stage and the register file write port.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RADDR_W, 5, register-file address width.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept this cycle
in_wb_sel  in  3  source select: 0 none, 1 load, 2 ALU, 3 imm (LUI), 4 PC+4 (JAL/JALR), 5 PC+imm (AUIPC), 6/7 reserved
in_rd  in  RADDR_W  destination register
in_ld_funct3  in  3  load funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
in_addr_lo  in  3  low bits of load address
in_mem_dout  in  XLEN  raw data-memory word
in_alu_res  in  XLEN  ALU result
in_imme  in  XLEN  immediate
in_pc_add_4  in  XLEN  PC+4
in_pc_add_imme  in  XLEN  PC+imm
stall  in  1  hazard unit holds the stage
flush  in  1  kill the held entry
rf_we  out  1  register-file write enable
rf_waddr  out  RADDR_W  write address
rf_wdata  out  XLEN  write data
fwd_valid  out  1  held entry will write rd
fwd_rd  out  RADDR_W  forwarding destination
fwd_data  out  XLEN  forwarding data (equals rf_wdata)
misalign_err  out  1  one-cycle pulse: misaligned or illegal load retired
retire_cnt  out  CNT_W  committed-instruction count

Behaviour:
- Reset (async): valid_q=0, all held fields 0, retire_cnt=0.
  - Hence rf_we=0, fwd_valid=0, misalign_err=0, in_ready=1, and rf_waddr/rf_wdata/fwd_rd/fwd_data=0.
- Handshake:
  - in_ready = ~valid_q | ~stall (combinational).
  - Capture at the edge when in_valid & in_ready.
  - The entry commits in any cycle with valid_q & ~stall & ~flush.
  - Commit and capture may occur in the same cycle (back-to-back throughput 1/cycle).
  - If the entry commits and nothing is captured, valid_q clears.
- Flush:
  - The held entry produces no write/error/count in the flush cycle.
  - valid_q clears at the next edge.
  - Flush has priority over capture: input is not taken that cycle.
  - in_ready follows its formula regardless of flush.
- Stall: all held state is frozen; no write, no count.
- Latency: an instruction captured at edge N writes the register file during cycle N..N+1, i.e. the first cycle it is held and not stalled.
- Load extraction from in_mem_dout, using addr_lo (bits [1:0] for XLEN=32, [2:0] for XLEN=64):
  - LB/LBU: byte lane addr_lo, sign/zero extended.
  - LH/LHU: halfword; addr_lo[0] must be 0.
  - LW: word; addr_lo[1:0] must be 0. LWU is legal only when XLEN=64 (zero-extended).
  - LD: legal only when XLEN=64; addr_lo must be 0.
  - Any other funct3 is illegal.
- Write data:
  - Comes from the select mux; reserved select values behave as none.
- Write enable:
  - rf_we = committing & wb_sel≠none & rd≠0 & ~bad_load.
  - bad_load = (wb_sel=load) & (misaligned | illegal funct3).
- misalign_err: high in the commit cycle of a bad_load entry; otherwise 0.
- Forwarding:
  - fwd_valid = valid_q & wb_sel≠none & rd≠0 & ~bad_load. It ignores stall, so the tap stays visible while the stage is held.
  - fwd_rd = held rd; fwd_data = held write data.
- retire_cnt:
  - +1 per commit, including no-write and bad-load commits.
  - Saturates at all-ones; flushed entries are not counted.

Test Plan:
- Reset mid-stream with valid_q=1, stall=1 → next cycle all outputs 0, in_ready=1, retire_cnt=0.
- ALU instr rd=5, alu_res=0x1234_5678, no stall → exactly one cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; retire_cnt=1.
- Loads with mem_dout=0x80FF_7F01:
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=3 → 0x00000080.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LW addr_lo=0 → 0x80FF7F01.
  - LH addr_lo=1 → rf_we=0, misalign_err=1 for one cycle, retire_cnt increments.
- rd=0 with wb_sel=ALU; wb_sel=7; and LD with XLEN=32 → rf_we=0 for all three; fwd_valid=0 for all three; misalign_err=1 only for the LD.
- Stall 3 cycles with a JAL held (pc_add_4=0x104) → in_ready=0; fwd_valid=1, fwd_data=0x104 throughout; no write until stall drops, then one write.
- Flush asserted with in_valid=1 while entry held → no write, no count, new input not captured. Back-to-back 4 ALU instrs without stall → 4 consecutive writes, retire_cnt=4. With CNT_W=2 → the counter saturates at 3.
